// File: rtl/mem_wait_bridge_pkg.sv
// Shared types and constants for the multicycle core's memory wait bridge.
package mem_wait_bridge_pkg;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_WAIT = 2'd1,
        MB_DONE = 2'd2
    } mb_state_t;

    localparam logic [31:0] MB_ERR_WORD = 32'hDEADBEEF;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic mb_is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mb_wait_timer.sv
// Saturating cycle counter that flags the last permitted ack-wait cycle.
module mb_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(LIMIT + 1);

    logic [TW-1:0] count;

    // Count wait cycles; hold at LIMIT so the value never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TW'(LIMIT))) begin
            count <= count + TW'(1);
        end
    end

    // High during the final wait cycle allowed before the access is aborted.
    assign expired = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/mem_wait_bridge.sv
// Freezes the multicycle core while one access runs on a variable-latency memory.
module mem_wait_bridge
    import mem_wait_bridge_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter int unsigned    TIMEOUT  = 255,
    parameter logic [DW-1:0]  ERR_WORD = DW'(MB_ERR_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          clk_en,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          bus_err
);

    mb_state_t state;
    mb_state_t state_n;

    logic load;
    logic misalign;
    logic ack_done;
    logic abort;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    mb_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_n   = state;
        clk_en    = 1'b1;
        load      = 1'b0;
        misalign  = 1'b0;
        ack_done  = 1'b0;
        abort     = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            MB_IDLE: begin
                clk_en    = ~cpu_req;
                timer_clr = 1'b1;
                if (cpu_req) begin
                    if (mb_is_aligned(cpu_addr[1:0])) begin
                        load    = 1'b1;
                        state_n = MB_WAIT;
                    end else begin
                        misalign = 1'b1;
                        state_n  = MB_DONE;
                    end
                end
            end
            MB_WAIT: begin
                clk_en = 1'b0;
                if (mem_ack) begin
                    ack_done = 1'b1;
                    state_n  = MB_DONE;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_n = MB_DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            MB_DONE: begin
                clk_en  = 1'b1;
                state_n = MB_IDLE;
            end
            default: begin
                state_n = MB_IDLE;
            end
        endcase
    end

    // Memory-side request registers, returned read data and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (load) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
            if (ack_done) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    cpu_rdata <= mem_rdata;
                end
            end
            if (abort || misalign) begin
                mem_req   <= 1'b0;
                cpu_rdata <= ERR_WORD;
                bus_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed self-checking bench for mem_wait_bridge (TIMEOUT reduced to 8).
module tb_mem_wait_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        clk_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int n_chk  = 0;
    int n_pass = 0;

    mem_wait_bridge #(
        .AW       (32),
        .DW       (32),
        .TIMEOUT  (8),
        .ERR_WORD (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .clk_en    (clk_en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it does not match.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Run one access from IDLE up to and including its DONE cycle.
    // ack_at is the WAIT cycle (1-based) carrying mem_ack; 0 means never ack.
    task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_at,
                              input logic [31:0] rdata, output int lo_cycles,
                              output int req_cycles, output logic stable);
        logic done;
        lo_cycles  = 0;
        req_cycles = 0;
        stable     = 1'b1;
        done       = 1'b0;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (clk_en) begin
                done      = 1'b1;
                cpu_req   = 1'b0;
                mem_ack   = 1'b0;
                break;
            end
            lo_cycles++;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) begin
                    stable = 1'b0;
                end
                if (req_cycles == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            chk({tag, "_done_in_budget"}, 32'(done), 32'd1);
            cpu_req = 1'b0;
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        int   lo;
        int   rq;
        logic st;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset values.
        #12;
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_cpu_rdata", cpu_rdata,      32'd0);
        chk("rst_bus_err",   32'(bus_err),   32'd0);
        chk("rst_clk_en",    32'(clk_en),    32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Read, ack in the first WAIT cycle.
        run_access("rd", 1'b0, 32'h40, 32'h0, 1, 32'h12345678, lo, rq, st);
        chk("rd_clk_en_low", 32'(lo), 32'd2);
        chk("rd_req_cycles", 32'(rq), 32'd1);
        chk("rd_stable",     32'(st), 32'd1);
        chk("rd_done_en",    32'(clk_en), 32'd1);
        chk("rd_rdata",      cpu_rdata, 32'h12345678);
        chk("rd_bus_err",    32'(bus_err), 32'd0);
        @(negedge clk); #1;
        chk("rd_idle_en",    32'(clk_en), 32'd1);
        chk("rd_idle_req",   32'(mem_req), 32'd0);

        // Write, ack in the fifth WAIT cycle; read data must not change.
        run_access("wr", 1'b1, 32'h44, 32'hCAFEF00D, 5, 32'h0BADF00D, lo, rq, st);
        chk("wr_clk_en_low", 32'(lo), 32'd6);
        chk("wr_req_cycles", 32'(rq), 32'd5);
        chk("wr_stable",     32'(st), 32'd1);
        chk("wr_rdata_kept", cpu_rdata, 32'h12345678);
        chk("wr_bus_err",    32'(bus_err), 32'd0);

        // Fetch then lw, back-to-back, each acked in one cycle.
        run_access("fetch", 1'b0, 32'h0, 32'h0, 1, 32'h11110000, lo, rq, st);
        chk("fetch_clk_en_low", 32'(lo), 32'd2);
        chk("fetch_req_cycles", 32'(rq), 32'd1);
        chk("fetch_rdata",      cpu_rdata, 32'h11110000);
        run_access("lw", 1'b0, 32'h8, 32'h0, 1, 32'h22220008, lo, rq, st);
        chk("lw_clk_en_low", 32'(lo), 32'd2);
        chk("lw_req_cycles", 32'(rq), 32'd1);
        chk("lw_stable",     32'(st), 32'd1);
        chk("lw_rdata",      cpu_rdata, 32'h22220008);
        chk("lw_done_req",   32'(mem_req), 32'd0);
        @(negedge clk); #1;
        chk("lw_no_dup_req", 32'(mem_req), 32'd0);
        chk("lw_bus_err",    32'(bus_err), 32'd0);

        // No ack: abort after 8 WAIT cycles.
        run_access("to", 1'b0, 32'h80, 32'h0, 0, 32'h0, lo, rq, st);
        chk("to_req_cycles", 32'(rq), 32'd8);
        chk("to_clk_en_low", 32'(lo), 32'd9);
        chk("to_done_req",   32'(mem_req), 32'd0);
        chk("to_rdata",      cpu_rdata, 32'hDEADBEEF);
        chk("to_bus_err",    32'(bus_err), 32'd1);
        @(negedge clk); #1;
        chk("to_idle_en",    32'(clk_en), 32'd1);
        chk("to_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of WAIT, then a late ack.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h100;
        @(negedge clk); #1;
        chk("mid_req_up", 32'(mem_req), 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_req_async", 32'(mem_req), 32'd0);
        chk("mid_bus_err",   32'(bus_err), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        cpu_req   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        #1;
        chk("late_ack_en",  32'(clk_en), 32'd1);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_rdata", cpu_rdata, 32'd0);
        chk("late_ack_err",   32'(bus_err), 32'd0);
        chk("late_ack_idle",  32'(clk_en), 32'd1);

        // Clean read after reset, then a misaligned read.
        run_access("rd2", 1'b0, 32'h40, 32'h0, 2, 32'h55AA55AA, lo, rq, st);
        chk("rd2_clk_en_low", 32'(lo), 32'd3);
        chk("rd2_rdata",      cpu_rdata, 32'h55AA55AA);
        run_access("mis", 1'b0, 32'h42, 32'h0, 1, 32'h0, lo, rq, st);
        chk("mis_clk_en_low", 32'(lo), 32'd1);
        chk("mis_req_cycles", 32'(rq), 32'd0);
        chk("mis_rdata",      cpu_rdata, 32'hDEADBEEF);
        chk("mis_bus_err",    32'(bus_err), 32'd1);
        @(negedge clk); #1;
        chk("mis_idle_req",   32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
